// File: rtl/eeg_loader_pkg.sv
// Shared types, constants and the ADC-to-intermediate-result conversion
// used by the EEG loader front end of the CIM accelerator.
package eeg_loader_pkg;

    localparam int unsigned ADC_BITWIDTH         = 16;
    localparam int unsigned INT_RES_ADDR_W       = 16;
    localparam int unsigned INT_RES_DOUBLE_W     = 30;
    localparam int unsigned Q_STO_INT_RES_DOUBLE = 20;
    localparam int unsigned NUM_PATCHES          = 60;
    localparam int unsigned PATCH_LEN            = 64;
    localparam int unsigned EEG_IDX_W            = 12;
    localparam int unsigned EEG_CENTRE_OFFSET    = 2 ** (ADC_BITWIDTH - 1);
    localparam int unsigned EEG_CONV_SHIFT       = Q_STO_INT_RES_DOUBLE - (ADC_BITWIDTH - 1);

    typedef logic [ADC_BITWIDTH-1:0]     AdcData_t;
    typedef logic [INT_RES_ADDR_W-1:0]   IntResAddr_t;
    typedef logic [INT_RES_DOUBLE_W-1:0] IntResDouble_t;

    typedef enum logic { SINGLE_WIDTH = 1'b0, DOUBLE_WIDTH = 1'b1 } DataWidth_t;
    typedef enum logic [2:0] { INT_RES_SW_FX = 3'd0, INT_RES_DW_FX = 3'd1 } FxFormatIntRes_t;
    typedef enum logic [1:0] { IDLE, LOAD, DRAIN, DONE } EegLoaderState_t;

    localparam IntResAddr_t     MEM_MAP_EEG_INPUT_MEM     = '0;
    localparam FxFormatIntRes_t INT_RES_FORMAT_EEG_FORMAT = INT_RES_DW_FX;

    // Re-centre the unsigned code around zero and place it in Q20 so the full
    // ADC range maps exactly onto [-1, 1).
    function automatic IntResDouble_t eeg_convert(input AdcData_t s);
        logic [ADC_BITWIDTH:0] centred;
        centred = {1'b0, s} - (ADC_BITWIDTH + 1)'(EEG_CENTRE_OFFSET);
        return {{(INT_RES_DOUBLE_W - ADC_BITWIDTH - 1){centred[ADC_BITWIDTH]}}, centred}
               << EEG_CONV_SHIFT;
    endfunction

endpackage

// File: rtl/eeg_loader_sync_fifo.sv
// Single-clock FIFO with registered first-word-fall-through read data and
// full/empty flags; push and pop may coincide, including when full.
module sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] data_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, remain;
    logic [WIDTH-1:0] head_q, head_d;
    logic             push_ok, pop_ok;

    assign pop_ok  = pop_i && (cnt_q != '0);
    assign push_ok = push_i && ((cnt_q != CNT_W'(DEPTH)) || pop_ok);
    assign remain  = cnt_q - CNT_W'(pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        head_d   = head_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            cnt_d = remain + CNT_W'(push_ok);
            // Head register pre-loads the next entry so data_o is valid the
            // cycle after a push into an empty FIFO.
            if (remain != '0)  head_d = mem_q[rd_ptr_d];
            else if (push_ok)  head_d = data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign data_o  = head_q;

endmodule

// File: rtl/eeg_loader.sv
// Loads one window of ADC samples into intermediate-result memory as
// re-centred double-width fixed point, tolerating write backpressure.
module eeg_loader
    import eeg_loader_pkg::*;
#(
    parameter int unsigned NUM_SAMPLES = NUM_PATCHES * PATCH_LEN,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter IntResAddr_t BASE_ADDR   = MEM_MAP_EEG_INPUT_MEM
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        sample_valid,
    input  logic [ADC_BITWIDTH-1:0]     sample,
    input  logic                        mem_busy,
    output logic                        mem_wr_en,
    output logic [INT_RES_ADDR_W-1:0]   mem_addr,
    output logic [INT_RES_DOUBLE_W-1:0] mem_data,
    output logic                        mem_width,
    output logic [2:0]                  mem_format,
    output logic                        busy,
    output logic                        done,
    output logic                        overflow
);

    localparam int unsigned PAYLOAD_W = EEG_IDX_W + INT_RES_DOUBLE_W;
    localparam logic [EEG_IDX_W-1:0] NUM_W = EEG_IDX_W'(NUM_SAMPLES);

    EegLoaderState_t       state_q, state_d;
    logic [EEG_IDX_W-1:0]  in_cnt_q, in_cnt_d, wr_cnt_q, wr_cnt_d;
    logic                  overflow_q, overflow_d;
    logic                  start_ok, push, accept;
    logic                  fifo_full, fifo_empty;
    logic [PAYLOAD_W-1:0]  fifo_wdata, fifo_rdata;
    logic [EEG_IDX_W-1:0]  head_idx;
    IntResDouble_t         head_data;

    assign start_ok   = start && (state_q == IDLE);
    assign push       = sample_valid && (state_q == LOAD);
    assign accept     = mem_wr_en && !mem_busy;
    assign fifo_wdata = {in_cnt_q, eeg_convert(sample)};
    assign {head_idx, head_data} = fifo_rdata;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PAYLOAD_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (start_ok),
        .push_i  (push),
        .pop_i   (accept),
        .data_i  (fifo_wdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .data_o  (fifo_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Drain also ends on an empty FIFO so a dropped final sample cannot stall.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    if (in_cnt_d == NUM_W) state_d = DRAIN;
            DRAIN:   if ((wr_cnt_d == NUM_W) || fifo_empty) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q == LOAD) || (state_q == DRAIN);
        done       = (state_q == DONE);
        mem_wr_en  = busy && !fifo_empty;
        mem_addr   = BASE_ADDR + IntResAddr_t'(head_idx);
        mem_data   = head_data;
        mem_width  = DOUBLE_WIDTH;
        mem_format = INT_RES_FORMAT_EEG_FORMAT;
        overflow   = overflow_q;
    end

    always_comb begin
        in_cnt_d   = in_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        overflow_d = overflow_q;
        if (start_ok) begin
            in_cnt_d   = '0;
            wr_cnt_d   = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) begin
                in_cnt_d = in_cnt_q + EEG_IDX_W'(1);
                if (fifo_full && !accept) overflow_d = 1'b1;
            end
            if (accept) wr_cnt_d = head_idx + EEG_IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            in_cnt_q   <= in_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_eeg_loader.sv
// Bench for eeg_loader: conversion vector table, full windows, backpressure,
// overflow, ignored strobes/starts and asynchronous reset mid-load.
module tb_eeg_loader;
    import eeg_loader_pkg::*;

    localparam int unsigned NS = 3840;

    logic        clk = 1'b0;
    logic        rst_n, start, sample_valid, mem_busy;
    logic [15:0] sample;
    logic        mem_wr_en, mem_width, busy, done, overflow;
    logic [15:0] mem_addr;
    logic [29:0] mem_data;
    logic [2:0]  mem_format;

    always #5 clk = ~clk;

    eeg_loader #(
        .NUM_SAMPLES (NS),
        .FIFO_DEPTH  (4),
        .BASE_ADDR   (16'd0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .sample_valid (sample_valid),
        .sample       (sample),
        .mem_busy     (mem_busy),
        .mem_wr_en    (mem_wr_en),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_width    (mem_width),
        .mem_format   (mem_format),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow)
    );

    typedef struct { logic [15:0] addr; logic [29:0] data; } wr_t;
    typedef struct { logic [15:0] smp; logic [15:0] addr; int data; } vec_t;

    wr_t  sb[$];
    wr_t  exp_w;
    vec_t tbl[6];
    int   n_cmp = 0, n_bad = 0;
    int   cycle = 0, last_acc = -10, done_cnt = 0;
    logic [29:0] held_data;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic int exp_conv(logic [15:0] s);
        return (int'(s) - 32768) * 32;
    endfunction

    // Scoreboard: every accepted write must match the oldest expected one.
    always @(negedge clk) begin
        if (rst_n && mem_wr_en && !mem_busy) begin
            last_acc = cycle;
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none", mem_addr, mem_data);
            end else begin
                exp_w = sb.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(exp_w.addr));
                chk("wr_data", 32'(mem_data), 32'(exp_w.data));
            end
        end
        if (done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(int idx, logic [15:0] s);
        wr_t w;
        w.addr = 16'(idx);
        w.data = 30'(exp_conv(s));
        sb.push_back(w);
    endtask

    task automatic drive(logic [15:0] s);
        sample       = s;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(int exp_cnt, logic exp_ovf);
        int k;
        k = 0;
        @(negedge clk);
        while (!done && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("done_seen", 32'(done), 32'd1);
        chk("done_latency", 32'(cycle), 32'(last_acc + 1));
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("ovf_at_done", 32'(overflow), 32'(exp_ovf));
        chk("sb_empty_at_done", 32'(sb.size()), 32'd0);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("done_count", 32'(done_cnt), 32'(exp_cnt));
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] s;
        tbl[0] = '{16'h8000, 16'd0, 0};
        tbl[1] = '{16'hFFFF, 16'd1, 1048544};
        tbl[2] = '{16'h0000, 16'd2, -1048576};
        tbl[3] = '{16'h8001, 16'd3, 32};
        tbl[4] = '{16'h7FFF, 16'd4, -32};
        tbl[5] = '{16'h0001, 16'd5, -1048544};

        rst_n = 1'b0; start = 1'b0; sample_valid = 1'b0; sample = '0; mem_busy = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_data", 32'(mem_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_width", 32'(mem_width), 32'(DOUBLE_WIDTH));
        chk("rst_format", 32'(mem_format), 32'(INT_RES_DW_FX));
        tick();
        rst_n = 1'b1;
        tick();

        // Strobe while idle must be ignored
        drive(16'h1234);
        repeat (3) tick();
        @(negedge clk);
        chk("idle_no_write", 32'(mem_wr_en), 32'd0);
        chk("idle_no_ovf", 32'(overflow), 32'd0);
        tick();

        // Window 1: vector table then random fill, one sample every 4 cycles
        do_start();
        for (int i = 0; i < int'(NS); i++) begin
            if (i < 6) begin
                exp_w.addr = tbl[i].addr;
                exp_w.data = 30'(tbl[i].data);
                sb.push_back(exp_w);
                s = tbl[i].smp;
            end else begin
                s = 16'($urandom);
                push_exp(i, s);
            end
            drive(s);
            if (i == 0) begin
                @(negedge clk);
                chk("latency_wr_en", 32'(mem_wr_en), 32'd1);
                chk("wr_width", 32'(mem_width), 32'(DOUBLE_WIDTH));
                chk("wr_format", 32'(mem_format), 32'(INT_RES_DW_FX));
                chk("busy_in_load", 32'(busy), 32'd1);
            end
            if (i != int'(NS) - 1) repeat (3) tick();
        end
        wait_done(1, 1'b0);

        // Window 2: backpressure, then a start pulse mid-load
        do_start();
        mem_busy = 1'b1;
        s = 16'hA5A5;
        push_exp(0, s);
        drive(s);
        @(negedge clk);
        chk("bp_wr_en", 32'(mem_wr_en), 32'd1);
        chk("bp_addr0", 32'(mem_addr), 32'd0);
        chk("bp_data0", 32'(mem_data), 32'(30'(exp_conv(16'hA5A5))));
        held_data = mem_data;
        s = 16'h1357;
        push_exp(1, s);
        sample = s; sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("bp_hold_en", 32'(mem_wr_en), 32'd1);
            chk("bp_hold_addr", 32'(mem_addr), 32'd0);
            chk("bp_hold_data", 32'(mem_data), 32'(held_data));
            tick();
        end
        mem_busy = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        chk("bp_no_ovf", 32'(overflow), 32'd0);
        chk("bp_sb_drained", 32'(sb.size()), 32'd0);
        tick();
        do_start();
        @(negedge clk);
        chk("start_ignored_busy", 32'(busy), 32'd1);
        tick();
        for (int i = 2; i < int'(NS); i++) begin
            s = 16'($urandom);
            push_exp(i, s);
            drive(s);
            if (i != int'(NS) - 1) tick();
        end
        wait_done(2, 1'b0);

        // Window 3: overflow with memory stalled for six strobes
        do_start();
        mem_busy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            s = 16'($urandom);
            if (k < 4) push_exp(k, s);
            drive(s);
        end
        @(negedge clk);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_head_addr", 32'(mem_addr), 32'd0);
        tick();
        mem_busy = 1'b0;
        for (int i = 6; i < int'(NS); i++) begin
            s = 16'($urandom);
            push_exp(i, s);
            drive(s);
            if (i != int'(NS) - 1) tick();
        end
        wait_done(3, 1'b1);

        // Window 4: start clears overflow, then reset at sample 1000
        do_start();
        @(negedge clk);
        chk("start_clears_ovf", 32'(overflow), 32'd0);
        tick();
        for (int i = 0; i <= 1000; i++) begin
            s = 16'($urandom);
            push_exp(i, s);
            drive(s);
        end
        chk("pre_rst_wr_en", 32'(mem_wr_en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_wr_en", 32'(mem_wr_en), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_done", 32'(done), 32'd0);
        sb.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        do_start();
        s = 16'hC000;
        push_exp(0, s);
        drive(s);
        @(negedge clk);
        chk("restart_addr", 32'(mem_addr), 32'd0);
        chk("restart_ovf", 32'(overflow), 32'd0);
        repeat (3) tick();
        chk("no_done_after_abort", 32'(done_cnt), 32'd3);
        chk("restart_sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
